// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Owns the single register-file write port and shares it between the pipeline
// write-back stage and an auxiliary multi-cycle unit. The pipeline has
// priority. Auxiliary results wait in a small FIFO and drain into idle
// write-back slots. A starvation guard stalls the pipeline for one cycle to
// force out an auxiliary result that has waited STARVE_LIMIT cycles.
//
// A pipeline write to address A marks every queued auxiliary entry for A as
// squashed. This keeps write-after-write ordering: the older auxiliary value
// must not overwrite the newer pipeline value. Squashed entries keep their
// FIFO slot and are popped later without a write.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   pipe_we      pipeline write-back request
//   pipe_waddr   pipeline destination register
//   pipe_wdata   pipeline write data
//   pipe_stall   pipeline must hold; pipe_* are ignored this cycle
//   aux_valid    auxiliary result valid
//   aux_waddr    auxiliary destination register
//   aux_wdata    auxiliary result data
//   aux_ready    FIFO can accept an entry (registered count < DEPTH)
//   rf_we        register-file write enable (registered)
//   rf_waddr     register-file write address (registered, held when idle)
//   rf_wdata     register-file write data (registered, held when idle)
//   aux_pending  FIFO occupancy, squashed entries included
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_we,
  input  logic [ADDR_W-1:0]        pipe_waddr,
  input  logic [DATA_W-1:0]        pipe_wdata,
  output logic                     pipe_stall,
  input  logic                     aux_valid,
  input  logic [ADDR_W-1:0]        aux_waddr,
  input  logic [DATA_W-1:0]        aux_wdata,
  output logic                     aux_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]   aux_pending
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  // FIFO storage
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_sq;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  state_t            state;
  state_t            state_next;

  logic head_valid;
  logic head_sq;
  logic push;
  logic pop;
  logic grant_pipe;
  logic grant_aux;

  assign head_valid  = (count != '0);
  assign head_sq     = q_sq[rd_ptr];
  assign aux_ready   = reset & (count < CNT_W'(DEPTH));
  assign push        = aux_valid & aux_ready;
  assign pipe_stall  = (state == ST_FORCE);
  assign aux_pending = count;

  // Grant decision. A squashed head is popped as soon as it reaches the
  // front, whether or not the pipeline is writing, so it never blocks the
  // entries behind it.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant_pipe = 1'b0;
    grant_aux  = 1'b0;
    pop        = 1'b0;
    if (state == ST_FORCE) begin
      pop       = head_valid;
      grant_aux = head_valid & ~head_sq;
    end else if (pipe_we) begin
      grant_pipe = 1'b1;
      pop        = head_valid & head_sq;
    end else if (head_valid) begin
      pop       = 1'b1;
      grant_aux = ~head_sq;
    end
  end

  // Starvation counter: counts cycles a live head is passed over and
  // saturates at the limit.
  always_comb begin
    wait_next = wait_cnt;
    if (pop) begin
      wait_next = '0;
    end else if (head_valid && !head_sq && wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_next = ST_NORMAL;
    if (state == ST_NORMAL && !pop && wait_next == WAIT_W'(STARVE_LIMIT)) begin
      state_next = ST_FORCE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      state    <= ST_NORMAL;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      wait_cnt <= wait_next;
      state    <= state_next;

      rf_we <= grant_pipe | grant_aux;
      if (grant_pipe) begin
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (grant_aux) begin
        rf_waddr <= q_addr[rd_ptr];
        rf_wdata <= q_data[rd_ptr];
      end
    end
  end

  // Squash marking. The push to wr_ptr is assigned last so an entry
  // enqueued in the same cycle as a matching pipeline write stays live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_sq <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (grant_pipe && q_addr[i] == pipe_waddr) q_sq[i] <= 1'b1;
      end
      if (push) q_sq[wr_ptr] <= 1'b0;
    end
  end

  // NOTE: the payload array is not reset; a slot is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= aux_waddr;
      q_data[wr_ptr] <= aux_wdata;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Inputs are driven at the falling edge and outputs are sampled at the
// falling edge. Every register-file write the bench expects is pushed to a
// queue when the stimulus that causes it is driven. The tick() task pops
// and compares the queue whenever rf_we is seen. A shadow register file
// records the writes that actually happened.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 3;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pipe_we;
  logic [ADDR_W-1:0]      pipe_waddr;
  logic [DATA_W-1:0]      pipe_wdata;
  logic                   pipe_stall;
  logic                   aux_valid;
  logic [ADDR_W-1:0]      aux_waddr;
  logic [DATA_W-1:0]      aux_wdata;
  logic                   aux_ready;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [$clog2(DEPTH):0] aux_pending;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] model_rf [1 << ADDR_W];
  int                n_cmp = 0;
  int                n_bad = 0;

  rf_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall),
    .aux_valid(aux_valid), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .aux_pending(aux_pending)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and score any write on the port.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (reset && rf_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          n_bad++;
          $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
      model_rf[rf_waddr] = rf_wdata;
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_pipe(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pipe_we    = we;
    pipe_waddr = a;
    pipe_wdata = d;
    if (we) expect_wr(a, d);
  endtask

  task automatic drive_aux(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    aux_valid = v;
    aux_waddr = a;
    aux_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_pipe(1'b0, '0, '0);
    drive_aux(1'b0, '0, '0);
    repeat (2) tick();
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || pipe_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h stall=%b, required all 0",
               rf_we, rf_waddr, rf_wdata, pipe_stall);
    end
    n_cmp++;
    if (aux_ready !== 1'b0 || aux_pending !== '0) begin
      n_bad++;
      $display("FAIL reset_aux: got ready=%b pending=%0d, required 0/0", aux_ready, aux_pending);
    end
    reset = 1'b1;
  endtask

  task automatic test_pipe_write();
    drive_pipe(1'b1, 3'd3, 16'h1234);
    tick();
    drive_pipe(1'b0, '0, '0);
    n_cmp++;
    if (aux_ready !== 1'b1 || aux_pending !== '0) begin
      n_bad++;
      $display("FAIL pipe_aux_idle: got ready=%b pending=%0d, required 1/0", aux_ready, aux_pending);
    end
    tick();
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL idle_hold: got we=%b addr=%0d data=%h, required 0/3/1234", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_aux_single();
    drive_aux(1'b1, 3'd5, 16'hBEEF);
    expect_wr(3'd5, 16'hBEEF);
    tick();
    drive_aux(1'b0, '0, '0);
    n_cmp++;
    if (aux_pending !== 3'd1) begin
      n_bad++;
      $display("FAIL aux_queued: got pending=%0d, required 1", aux_pending);
    end
    tick();
    n_cmp++;
    if (rf_we !== 1'b1 || aux_pending !== '0) begin
      n_bad++;
      $display("FAIL aux_drain: got we=%b pending=%0d, required 1/0", rf_we, aux_pending);
    end
  endtask

  task automatic test_fifo_full();
    logic [ADDR_W-1:0] aa [4];
    aa[0] = 3'd1; aa[1] = 3'd2; aa[2] = 3'd3; aa[3] = 3'd6;
    // Keep the pipeline busy so the entries accumulate.
    for (int i = 0; i < 4; i++) begin
      drive_pipe(1'b1, 3'd7, 16'h7000 + 16'(i));
      drive_aux(1'b1, aa[i], 16'hA000 + 16'(i));
      tick();
    end
    n_cmp++;
    if (aux_ready !== 1'b0 || aux_pending !== 3'd4) begin
      n_bad++;
      $display("FAIL full_flags: got ready=%b pending=%0d, required 0/4", aux_ready, aux_pending);
    end
    drive_pipe(1'b1, 3'd7, 16'h7004);
    drive_aux(1'b1, 3'd5, 16'hDEAD);
    tick();
    n_cmp++;
    if (aux_pending !== 3'd4) begin
      n_bad++;
      $display("FAIL full_reject: got pending=%0d, required 4", aux_pending);
    end
    drive_pipe(1'b0, '0, '0);
    drive_aux(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) expect_wr(aa[i], 16'hA000 + 16'(i));
    repeat (6) tick();
    n_cmp++;
    if (aux_pending !== '0) begin
      n_bad++;
      $display("FAIL full_drained: got pending=%0d, required 0", aux_pending);
    end
  endtask

  task automatic test_starvation();
    int stalls = 0;
    drive_aux(1'b1, 3'd2, 16'h0001);
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (pipe_stall !== (k == 9)) begin
        n_bad++;
        $display("FAIL starve_stall_c%0d: got stall=%b, required %b", k, pipe_stall, (k == 9));
      end
      if (pipe_stall === 1'b1) stalls++;
      if (k == 9) expect_wr(3'd2, 16'h0001);
      else        drive_pipe(1'b1, 3'd7, 16'h7700 + 16'(k));
      tick();
      if (k == 0) drive_aux(1'b0, '0, '0);
    end
    drive_pipe(1'b0, '0, '0);
    tick();
    n_cmp++;
    if (stalls != 1) begin
      n_bad++;
      $display("FAIL starve_count: got %0d stall cycles, required 1", stalls);
    end
  endtask

  task automatic test_squash();
    // Older aux entry for r4 is overtaken by a pipeline write to r4.
    drive_pipe(1'b1, 3'd6, 16'h6666);
    drive_aux(1'b1, 3'd4, 16'h4444);
    tick();
    drive_aux(1'b0, '0, '0);
    drive_pipe(1'b1, 3'd4, 16'hAAAA);
    tick();
    drive_pipe(1'b0, '0, '0);
    n_cmp++;
    if (aux_pending !== 3'd1) begin
      n_bad++;
      $display("FAIL squash_occupies: got pending=%0d, required 1", aux_pending);
    end
    tick();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL squash_pop: got we=%b, required 0", rf_we);
    end
    repeat (2) tick();
    n_cmp++;
    if (model_rf[4] !== 16'hAAAA || aux_pending !== '0) begin
      n_bad++;
      $display("FAIL squash_result: got r4=%h pending=%0d, required AAAA/0", model_rf[4], aux_pending);
    end
    // Same-cycle collision: the pushed entry is younger and writes later.
    drive_pipe(1'b1, 3'd1, 16'h1111);
    drive_aux(1'b1, 3'd1, 16'h2222);
    expect_wr(3'd1, 16'h2222);
    tick();
    drive_pipe(1'b0, '0, '0);
    drive_aux(1'b0, '0, '0);
    repeat (3) tick();
    n_cmp++;
    if (model_rf[1] !== 16'h2222) begin
      n_bad++;
      $display("FAIL collide_result: got r1=%h, required 2222", model_rf[1]);
    end
  endtask

  task automatic test_reset_mid();
    drive_pipe(1'b1, 3'd7, 16'h7A00);
    drive_aux(1'b1, 3'd1, 16'h0111);
    tick();
    drive_pipe(1'b1, 3'd7, 16'h7A01);
    drive_aux(1'b1, 3'd2, 16'h0222);
    tick();
    drive_pipe(1'b0, '0, '0);
    drive_aux(1'b0, '0, '0);
    expect_wr(3'd1, 16'h0111);
    tick();
    // Second entry would be granted at the next rising edge; reset first.
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || pipe_stall !== 1'b0 ||
        aux_pending !== '0 || aux_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got we=%b addr=%0d data=%h stall=%b pend=%0d ready=%b, required all 0",
               rf_we, rf_waddr, rf_wdata, pipe_stall, aux_pending, aux_ready);
    end
    tick();
    reset = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (aux_pending !== '0 || aux_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_after: got pending=%0d ready=%b, required 0/1", aux_pending, aux_ready);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) model_rf[i] = '0;
    test_reset();
    test_pipe_write();
    test_aux_single();
    test_fifo_full();
    test_starvation();
    test_squash();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
